// File: rtl/jtdsp16_host_cmd.sv
// Host-to-DSP16 command queue: assembles host byte writes into {addr,data}
// entries, hands them to the DSP through an irq/iack/pids_n handshake.
module jtdsp16_host_cmd #(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cen,
    input  logic        i_host_we,
    input  logic [1:0]  i_host_sel,
    input  logic [7:0]  i_host_din,
    input  logic        i_host_rsel,
    output logic [7:0]  o_host_dout,
    output logic        o_host_ready,
    output logic        o_host_ovf,
    output logic [15:0] o_pbus_in,
    input  logic [15:0] i_pbus_out,
    input  logic        i_pids_n,
    input  logic        i_pods_n,
    input  logic        i_psel,
    output logic        o_irq,
    input  logic        i_iack,
    output logic        o_busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_irq;
    logic        w_irq_next;

    logic [7:0]  r_data_hi;
    logic [7:0]  r_data_lo;
    logic [23:0] r_fifo [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        r_ovf;
    logic [15:0] r_result;
    logic        r_pids_q;
    logic        r_pods_q;

    logic        w_full;
    logic        w_empty;
    logic [23:0] w_head;
    logic        w_pids_rise;
    logic        w_pods_rise;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;

    assign w_full      = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
    assign w_empty     = (r_wr == r_rd);
    assign w_head      = r_fifo[r_rd[AW-1:0]];
    assign w_pids_rise = i_pids_n & ~r_pids_q;
    assign w_pods_rise = i_pods_n & ~r_pods_q;
    assign w_push_req  = i_host_we && (i_host_sel == 2'd2);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_pop     = i_cen && (r_state == SERVE) && w_pids_rise && !i_psel;
    assign w_push    = i_cen && w_push_req && (!w_full || w_pop);
    assign w_ovf_set = i_cen && w_push_req && w_full && !w_pop;

    assign o_host_ready = !w_full;
    assign o_host_ovf   = r_ovf;
    assign o_host_dout  = i_host_rsel ? r_result[15:8] : r_result[7:0];
    assign o_irq        = r_irq;
    assign o_busy       = (r_state != IDLE) || !w_empty;

    always_comb begin
        o_pbus_in = 16'h0000;
        if (r_state == SERVE) begin
            o_pbus_in = i_psel ? {8'h00, w_head[23:16]} : w_head[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_hi <= 8'h00;
            r_data_lo <= 8'h00;
            r_wr      <= '0;
            r_rd      <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= 24'h000000;
            end
        end else if (i_cen) begin
            if (i_host_we && i_host_sel == 2'd0) r_data_hi <= i_host_din;
            if (i_host_we && i_host_sel == 2'd1) r_data_lo <= i_host_din;
            if (w_push) begin
                r_fifo[r_wr[AW-1:0]] <= {i_host_din, r_data_hi, r_data_lo};
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    // Strobes idle high, so the history resets to 1 to avoid a phantom edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pids_q <= 1'b1;
            r_pods_q <= 1'b1;
            r_result <= 16'h0000;
        end else if (i_cen) begin
            r_pids_q <= i_pids_n;
            r_pods_q <= i_pods_n;
            if (w_pods_rise) r_result <= i_pbus_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
        end else if (i_cen) begin
            r_state <= w_state_next;
            r_irq   <= w_irq_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_irq_next   = r_irq;
        case (r_state)
            IDLE: begin
                w_irq_next = 1'b0;
                if (!w_empty) begin
                    w_state_next = REQ;
                    w_irq_next   = 1'b1;
                end
            end
            REQ: begin
                w_irq_next = 1'b1;
                if (i_iack) begin
                    w_state_next = SERVE;
                    w_irq_next   = 1'b0;
                end
            end
            SERVE: begin
                w_irq_next = 1'b0;
                if (w_pids_rise && !i_psel) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_irq_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jtdsp16_host_cmd.sv
// Self-checking bench for jtdsp16_host_cmd: a scoreboard queue models the FIFO,
// a vector table covers the result register, hand sequences cover handshakes.
module tb_jtdsp16_host_cmd;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        hostWe;
    logic [1:0]  hostSel;
    logic [7:0]  hostDin;
    logic        hostRsel;
    logic [7:0]  hostDout;
    logic        hostReady;
    logic        hostOvf;
    logic [15:0] pbusIn;
    logic [15:0] pbusOut;
    logic        pidsN;
    logic        podsN;
    logic        psel;
    logic        irq;
    logic        iack;
    logic        busy;

    jtdsp16_host_cmd #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cen        (cen),
        .i_host_we    (hostWe),
        .i_host_sel   (hostSel),
        .i_host_din   (hostDin),
        .i_host_rsel  (hostRsel),
        .o_host_dout  (hostDout),
        .o_host_ready (hostReady),
        .o_host_ovf   (hostOvf),
        .o_pbus_in    (pbusIn),
        .i_pbus_out   (pbusOut),
        .i_pids_n     (pidsN),
        .i_pods_n     (podsN),
        .i_psel       (psel),
        .o_irq        (irq),
        .i_iack       (iack),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] busVal;
        logic [7:0]  expLo;
        logic [7:0]  expHi;
    } resultVec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } pushVec_t;

    int testCount = 0;
    int failCount = 0;
    logic [23:0] sbQ[$];

    task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] din);
        hostWe  = 1'b1;
        hostSel = sel;
        hostDin = din;
        tick();
        hostWe  = 1'b0;
    endtask

    task automatic pushEntry(input logic [7:0] addr, input logic [15:0] data);
        applyStimulus(2'd0, data[15:8]);
        applyStimulus(2'd1, data[7:0]);
        if (sbQ.size() < DEPTH) sbQ.push_back({addr, data});
        applyStimulus(2'd2, addr);
    endtask

    task automatic waitIrq(input string name);
        int n = 0;
        while (!irq && n < 8) begin
            tick();
            n++;
        end
        checkOutput(name, {23'd0, irq}, 24'd1);
    endtask

    task automatic enterServe(input string name);
        waitIrq({name, "_irq"});
        iack = 1'b1;
        tick();
        iack = 1'b0;
        checkOutput({name, "_irq_after_iack"}, {23'd0, irq}, 24'd0);
    endtask

    // Handshake one entry out of SERVE and compare against the scoreboard head
    task automatic serveEntry(input string name);
        logic [23:0] exp;
        enterServe(name);
        if (sbQ.size() == 0) begin
            checkOutput({name, "_sb_nonempty"}, 24'd0, 24'd1);
            exp = 24'd0;
        end else begin
            exp = sbQ.pop_front();
        end
        psel  = 1'b1;
        pidsN = 1'b0;
        tick();
        pidsN = 1'b1;
        #1;
        checkOutput({name, "_addr"}, {8'h00, pbusIn}, {16'h0000, exp[23:16]});
        tick();
        psel = 1'b0;
        #1;
        checkOutput({name, "_data"}, {8'h00, pbusIn}, {8'h00, exp[15:0]});
        pidsN = 1'b0;
        tick();
        pidsN = 1'b1;
        tick();
        checkOutput({name, "_irq_gap"}, {23'd0, irq}, 24'd0);
    endtask

    task automatic podsPulse(input logic [15:0] val);
        pbusOut = val;
        podsN   = 1'b0;
        tick();
        podsN   = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resultVec_t resVecs[3];
        pushVec_t   fillVecs[5];
        pushVec_t   simVecs[4];
        logic       sawIrq;

        resVecs[0] = '{16'hBEEF, 8'hEF, 8'hBE};
        resVecs[1] = '{16'h1357, 8'h57, 8'h13};
        resVecs[2] = '{16'hA5C3, 8'hC3, 8'hA5};

        fillVecs[0] = '{8'h01, 16'h1111};
        fillVecs[1] = '{8'h02, 16'h2222};
        fillVecs[2] = '{8'h03, 16'h3333};
        fillVecs[3] = '{8'h04, 16'h4444};
        fillVecs[4] = '{8'h05, 16'h5555};

        simVecs[0] = '{8'h21, 16'hA001};
        simVecs[1] = '{8'h22, 16'hA002};
        simVecs[2] = '{8'h23, 16'hA003};
        simVecs[3] = '{8'h24, 16'hA004};

        rst = 1'b1; cen = 1'b1; hostWe = 1'b0; hostSel = 2'd0; hostDin = 8'h00;
        hostRsel = 1'b0; pbusOut = 16'h0000; pidsN = 1'b1; podsN = 1'b1;
        psel = 1'b0; iack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_irq",   {23'd0, irq},       24'd0);
        checkOutput("reset_ready", {23'd0, hostReady}, 24'd1);
        checkOutput("reset_ovf",   {23'd0, hostOvf},   24'd0);
        checkOutput("reset_busy",  {23'd0, busy},      24'd0);
        checkOutput("reset_pbus",  {8'h00, pbusIn},    24'd0);
        checkOutput("reset_dout",  {16'h0000, hostDout}, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic single command
        pushEntry(8'h80, 16'h1234);
        checkOutput("basic_irq_not_yet", {23'd0, irq}, 24'd0);
        tick();
        checkOutput("basic_irq_latency", {23'd0, irq}, 24'd1);
        checkOutput("basic_pbus_in_req", {8'h00, pbusIn}, 24'd0);
        serveEntry("basic");
        checkOutput("basic_busy_after", {23'd0, busy}, 24'd0);

        // iack while idle does nothing
        iack = 1'b1;
        tick();
        iack = 1'b0;
        tick();
        checkOutput("idle_iack_busy", {23'd0, busy}, 24'd0);
        checkOutput("idle_iack_irq",  {23'd0, irq},  24'd0);

        // pids_n edge while in REQ must not pop
        pushEntry(8'h11, 16'hAAAA);
        tick();
        pidsN = 1'b0;
        tick();
        pidsN = 1'b1;
        tick();
        checkOutput("req_pids_irq",  {23'd0, irq},  24'd1);
        checkOutput("req_pids_busy", {23'd0, busy}, 24'd1);
        serveEntry("req_pids");
        checkOutput("req_pids_busy_after", {23'd0, busy}, 24'd0);

        // Push and pop in the same cycle with the FIFO full
        for (int i = 0; i < 4; i++) pushEntry(simVecs[i].addr, simVecs[i].data);
        checkOutput("sim_full_ready", {23'd0, hostReady}, 24'd0);
        enterServe("sim");
        applyStimulus(2'd0, 8'hC0);
        applyStimulus(2'd1, 8'hDE);
        psel  = 1'b0;
        pidsN = 1'b0;
        tick();
        pidsN   = 1'b1;
        hostWe  = 1'b1;
        hostSel = 2'd2;
        hostDin = 8'h2F;
        #1;
        checkOutput("sim_head_data", {8'h00, pbusIn}, {8'h00, sbQ[0][15:0]});
        void'(sbQ.pop_front());
        sbQ.push_back({8'h2F, 16'hC0DE});
        tick();
        hostWe = 1'b0;
        checkOutput("sim_still_full", {23'd0, hostReady}, 24'd0);
        checkOutput("sim_no_ovf",     {23'd0, hostOvf},   24'd0);
        for (int i = 0; i < 4; i++) serveEntry($sformatf("sim_drain%0d", i));
        checkOutput("sim_busy_after", {23'd0, busy}, 24'd0);

        // Fill to capacity then overflow
        for (int i = 0; i < 5; i++) begin
            pushEntry(fillVecs[i].addr, fillVecs[i].data);
            if (i == 3) begin
                checkOutput("fill_ready_full", {23'd0, hostReady}, 24'd0);
                checkOutput("fill_ovf_clear",  {23'd0, hostOvf},   24'd0);
            end
        end
        checkOutput("fill_ovf_set", {23'd0, hostOvf}, 24'd1);
        for (int i = 0; i < 4; i++) serveEntry($sformatf("fill_drain%0d", i));
        checkOutput("fill_busy_after",  {23'd0, busy},      24'd0);
        checkOutput("fill_ready_after", {23'd0, hostReady}, 24'd1);
        checkOutput("fill_ovf_sticky",  {23'd0, hostOvf},   24'd1);

        // Result register vectors
        for (int i = 0; i < 3; i++) begin
            podsPulse(resVecs[i].busVal);
            hostRsel = 1'b0;
            #1;
            checkOutput($sformatf("result%0d_lo", i), {16'h0000, hostDout}, {16'h0000, resVecs[i].expLo});
            hostRsel = 1'b1;
            #1;
            checkOutput($sformatf("result%0d_hi", i), {16'h0000, hostDout}, {16'h0000, resVecs[i].expHi});
        end

        // Clock enable held low freezes everything
        cen = 1'b0;
        applyStimulus(2'd0, 8'h99);
        applyStimulus(2'd1, 8'h88);
        applyStimulus(2'd2, 8'h77);
        podsPulse(16'h5555);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        hostRsel = 1'b0;
        #1;
        checkOutput("cen0_result", {16'h0000, hostDout}, 24'h0000C3);
        checkOutput("cen0_busy",   {23'd0, busy},        24'd0);
        cen = 1'b1;
        repeat (3) tick();
        checkOutput("cen0_no_irq",  {23'd0, irq},  24'd0);
        checkOutput("cen0_no_push", {23'd0, busy}, 24'd0);

        // Reset asserted while serving with two entries queued
        pushEntry(8'h31, 16'hB001);
        pushEntry(8'h32, 16'hB002);
        enterServe("rst_mid");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_irq",   {23'd0, irq},       24'd0);
        checkOutput("rst_mid_ready", {23'd0, hostReady}, 24'd1);
        checkOutput("rst_mid_ovf",   {23'd0, hostOvf},   24'd0);
        checkOutput("rst_mid_busy",  {23'd0, busy},      24'd0);
        checkOutput("rst_mid_pbus",  {8'h00, pbusIn},    24'd0);
        hostRsel = 1'b1;
        #1;
        checkOutput("rst_mid_result", {16'h0000, hostDout}, 24'd0);
        sbQ.delete();
        @(negedge clk);
        rst = 1'b0;
        sawIrq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (irq) sawIrq = 1'b1;
        end
        checkOutput("rst_mid_no_irq", {23'd0, sawIrq}, 24'd0);
        pushEntry(8'h40, 16'hCAFE);
        serveEntry("post_rst");
        checkOutput("post_rst_busy", {23'd0, busy}, 24'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
